// File: rtl/fifo_rd_fwft_if.sv
// Read-side stream bundle: FIFO strobe side (rempty/rinc/mem_rdata) and
// first-word-fall-through sink side (dout/dout_valid/dout_ready/level).
interface fifo_rd_fwft_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] mem_rdata;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [1:0]       level;

  modport master (
    input  rempty, mem_rdata, dout_ready,
    output rinc, dout, dout_valid, level
  );

  modport slave (
    output rempty, mem_rdata, dout_ready,
    input  rinc, dout, dout_valid, level
  );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through output stage for the async FIFO read domain, with a
// small prefetch buffer. Optional pop counter enabled by FIFO_RD_FWFT_CNT_EN.
module fifo_rd_fwft #(
  parameter int DSIZE   = 8,
  parameter int MEM_LAT = 0
) (
  input  logic          rclk,
  input  logic          rrst_n,
`ifdef FIFO_RD_FWFT_CNT_EN
  input  logic          cnt_clr,
  output logic [15:0]   pop_cnt,
`endif
  fifo_rd_fwft_if.master bus
);

  localparam int BUF_DEPTH = MEM_LAT + 2;
  localparam int IW        = $clog2(BUF_DEPTH);

  generate
    if (MEM_LAT != 0 && MEM_LAT != 1) begin : g_bad_mem_lat
      $error("fifo_rd_fwft: MEM_LAT must be 0 or 1");
    end
  endgenerate

  logic [DSIZE-1:0] buf_q [BUF_DEPTH];
  logic [DSIZE-1:0] buf_d [BUF_DEPTH];
  logic [1:0]       count_q, count_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic             inflight_q, inflight_d;
  logic             issue, push, pop;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == IW'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A slot is reserved for every word already in flight, so the buffer never overflows.
  always_comb begin
    bus.rinc = rrst_n & ~bus.rempty &
               (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
  end

  assign issue          = bus.rinc & ~bus.rempty;
  assign pop            = bus.dout_valid & bus.dout_ready;
  assign bus.dout_valid = (count_q != 2'd0);
  assign bus.dout       = buf_q[rd_idx_q];
  assign bus.level      = count_q;

  always_comb begin
    buf_d      = buf_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    count_d    = count_q;
    push       = 1'b0;
    inflight_d = 1'b0;

    // Registered memory returns data one edge after the issue edge.
    if (MEM_LAT == 0) begin
      push = issue;
    end else begin
      push       = inflight_q;
      inflight_d = issue;
    end

    if (push) begin
      buf_d[wr_idx_q] = bus.mem_rdata;
      wr_idx_d        = idx_inc(wr_idx_q);
    end
    if (pop) begin
      rd_idx_d = idx_inc(rd_idx_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      count_q    <= 2'd0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      count_q    <= count_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_RD_FWFT_CNT_EN
  logic [15:0] pop_cnt_q, pop_cnt_d;

  // Clear takes priority over a coincident pop; the count saturates.
  always_comb begin
    pop_cnt_d = pop_cnt_q;
    if (cnt_clr) begin
      pop_cnt_d = 16'd0;
    end else if (pop && (pop_cnt_q != 16'hFFFF)) begin
      pop_cnt_d = pop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_cnt_q <= 16'd0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign pop_cnt = pop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Scoreboard bench for fifo_rd_fwft: one instance per memory latency, both fed
// from a behavioural FIFO model; a negedge monitor checks every delivered word.
module tb_fifo_rd_fwft;
  localparam int DW    = 8;
  localparam int NL    = 2;
  localparam int SRC_N = 4096;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_fwft_if #(.DSIZE(DW)) bus0 ();
  fifo_rd_fwft_if #(.DSIZE(DW)) bus1 ();

`ifdef FIFO_RD_FWFT_CNT_EN
  logic        cnt_clr;
  logic [15:0] pop_cnt_w [NL];
`endif

  fifo_rd_fwft #(.DSIZE(DW), .MEM_LAT(0)) dut0 (
    .rclk(rclk), .rrst_n(rrst_n),
`ifdef FIFO_RD_FWFT_CNT_EN
    .cnt_clr(cnt_clr), .pop_cnt(pop_cnt_w[0]),
`endif
    .bus(bus0.master)
  );

  fifo_rd_fwft #(.DSIZE(DW), .MEM_LAT(1)) dut1 (
    .rclk(rclk), .rrst_n(rrst_n),
`ifdef FIFO_RD_FWFT_CNT_EN
    .cnt_clr(cnt_clr), .pop_cnt(pop_cnt_w[1]),
`endif
    .bus(bus1.master)
  );

  // Behavioural FIFO: one shared word stream, one read pointer per lane.
  logic [DW-1:0] src_mem [SRC_N];
  logic [11:0]   src_wr;
  logic [11:0]   src_rd [NL];
  logic          force_empty;
  logic          ready;
  logic [DW-1:0] mem_r1;

  logic          rempty_w [NL];
  logic          rinc_w   [NL];
  logic          dv_w     [NL];
  logic [DW-1:0] dout_w   [NL];
  logic [1:0]    lvl_w    [NL];

  always_comb begin
    for (int i = 0; i < NL; i++) rempty_w[i] = force_empty | (src_rd[i] == src_wr);
  end

  assign bus0.rempty     = rempty_w[0];
  assign bus1.rempty     = rempty_w[1];
  assign bus0.mem_rdata  = src_mem[src_rd[0]];
  assign bus1.mem_rdata  = mem_r1;
  assign bus0.dout_ready = ready;
  assign bus1.dout_ready = ready;
  assign rinc_w[0] = bus0.rinc;        assign rinc_w[1] = bus1.rinc;
  assign dv_w[0]   = bus0.dout_valid;  assign dv_w[1]   = bus1.dout_valid;
  assign dout_w[0] = bus0.dout;        assign dout_w[1] = bus1.dout;
  assign lvl_w[0]  = bus0.level;       assign lvl_w[1]  = bus1.level;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < NL; i++) src_rd[i] <= src_wr;
      mem_r1 <= '0;
    end else begin
      if (rinc_w[1] && !rempty_w[1]) mem_r1 <= src_mem[src_rd[1]];
      for (int i = 0; i < NL; i++)
        if (rinc_w[i] && !rempty_w[i]) src_rd[i] <= src_rd[i] + 12'd1;
    end
  end

  // Directed expectations handed from stimulus to the monitor.
  int req_id = 0;
  int req_seen = 0;
  int req_lvl  [NL];
  int req_left [NL];
  bit req_drain;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_rd [NL];
  logic        hold_v [NL];
  logic [DW-1:0] hold_d [NL];
  int          cnt_m  [NL];

  task automatic chk(input string nm, input int lane, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s lane%0d: got %0d, expected %0d at %0t", nm, lane, act, exp_v, $time);
    end
  endtask

  always @(negedge rclk) begin
    for (int i = 0; i < NL; i++) begin
      if (!rrst_n) begin
        chk("rst_rinc",  i, int'(rinc_w[i]), 0);
        chk("rst_valid", i, int'(dv_w[i]), 0);
        chk("rst_level", i, int'(lvl_w[i]), 0);
        chk("rst_dout",  i, int'(dout_w[i]), 0);
        exp_rd[i] = src_wr;
        hold_v[i] = 1'b0;
        cnt_m[i]  = 0;
      end else begin
        if (rempty_w[i]) chk("rinc_while_empty", i, int'(rinc_w[i]), 0);
        chk("valid_vs_level", i, int'(dv_w[i]), int'(lvl_w[i] != 2'd0));
        chk("level_max", i, int'(int'(lvl_w[i]) <= i + 2), 1);
        if (hold_v[i]) begin
          chk("hold_valid", i, int'(dv_w[i]), 1);
          chk("hold_data",  i, int'(dout_w[i]), int'(hold_d[i]));
        end
`ifdef FIFO_RD_FWFT_CNT_EN
        chk("pop_cnt", i, int'(pop_cnt_w[i]), cnt_m[i]);
        if (cnt_clr) cnt_m[i] = 0;
        else if (dv_w[i] && ready && cnt_m[i] != 65535) cnt_m[i]++;
`endif
        if (dv_w[i] && ready) begin
          if (exp_rd[i] == src_wr) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word lane%0d: got %0d, expected no word at %0t",
                     i, dout_w[i], $time);
          end else begin
            chk("data", i, int'(dout_w[i]), int'(src_mem[exp_rd[i]]));
            exp_rd[i] = exp_rd[i] + 12'd1;
          end
        end
        hold_v[i] = dv_w[i] & ~ready;
        hold_d[i] = dout_w[i];
      end
    end
    if (req_id != req_seen) begin
      for (int i = 0; i < NL; i++) begin
        if (req_lvl[i] >= 0)  chk("level", i, int'(lvl_w[i]), req_lvl[i]);
        if (req_left[i] >= 0) chk("src_left", i, int'(src_wr - src_rd[i]), req_left[i]);
        if (req_drain)        chk("undelivered", i, int'(src_wr - exp_rd[i]), 0);
      end
      req_seen = req_id;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    src_mem[src_wr] = d;
    src_wr = src_wr + 12'd1;
  endtask

  task automatic request(input int l0, input int l1, input int s0, input int s1, input bit drain);
    req_lvl[0] = l0; req_lvl[1] = l1;
    req_left[0] = s0; req_left[1] = s1;
    req_drain = drain;
    req_id++;
  endtask

  initial begin
    ready = 1'b0;
    force_empty = 1'b0;
    src_wr = '0;
`ifdef FIFO_RD_FWFT_CNT_EN
    cnt_clr = 1'b0;
`endif
    step(3);

    // Idle after reset with an empty FIFO.
    rrst_n = 1'b1;
    step(8);
    request(0, 0, 0, 0, 1'b1);
    step(1);

    // Three words, sink always ready: latency 1 for lane0, 2 for lane1.
    ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    request(0, 0, 3, 3, 1'b0);
    step(1);
    request(1, 0, 2, 2, 1'b0);
    step(1);
    request(1, 1, 1, 1, 1'b0);
    step(6);
    request(0, 0, 0, 0, 1'b1);
    step(1);

    // Sink stalled: buffer fills to its depth, then drains gap-free.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(8'hA0 + 8'(k));
    step(10);
    request(2, 3, 3, 2, 1'b0);
    ready = 1'b1;
    step(5);
    request(0, 0, 0, 0, 1'b1);
    step(1);

    // Alternating back-pressure with continuous supply.
    for (int k = 0; k < 40; k++) begin
      push_word(8'($urandom));
      ready = (k % 2 == 0);
      step(1);
    end

    // Random supply, back-pressure and spurious empty flags.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 6) push_word(8'($urandom));
      ready = ($urandom_range(0, 1) == 1);
      force_empty = ($urandom_range(0, 9) == 0);
      step(1);
    end
    force_empty = 1'b0;
    ready = 1'b1;
    step(200);
    request(0, 0, 0, 0, 1'b1);
    step(1);

    // Empty flag rises mid-cycle while rinc is high: nothing is captured.
    ready = 1'b0;
    push_word(8'h5A);
    #2 force_empty = 1'b1;
    step(1);
    request(0, 0, 1, 1, 1'b0);
    step(1);
    request(0, 0, 1, 1, 1'b0);
    force_empty = 1'b0;
    ready = 1'b1;
    step(4);
    request(0, 0, 0, 0, 1'b1);
    step(1);

    // Reset mid-stream discards buffered and in-flight words.
    ready = 1'b0;
    for (int k = 0; k < 6; k++) push_word(8'hC0 + 8'(k));
    step(3);
    #2 rrst_n = 1'b0;
    step(2);
    rrst_n = 1'b1;
    step(3);
    request(0, 0, 0, 0, 1'b1);
    step(1);

`ifdef FIFO_RD_FWFT_CNT_EN
    // 300 pops, then a clear coincident with a pop.
    ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      push_word(8'(k));
      step(1);
    end
    push_word(8'hEE); push_word(8'hEF);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    step(6);
    request(0, 0, 0, 0, 1'b1);
    step(1);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
